// File: rtl/regular_min_max_inference.sv
// Bit-serial min/max fuzzy inference stage.
// Each rule i receives its antecedent degrees A_i and B_i MSB-first, one bit per cycle.
// The rule strength min(A_i, B_i) and the overall max over rules are both resolved
// bit-serially, so no degree is ever held in parallel form. The winning rule is tracked
// with a candidate mask that keeps the rules whose min still equals the running max.
module regular_min_max_inference #(
    parameter int N_RULES = 4,
    parameter int WIDTH   = 10,
    parameter int IDX_W   = (N_RULES > 1) ? $clog2(N_RULES) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               io_start,
    input  logic               io_inValid,
    input  logic [N_RULES-1:0] io_inA,
    input  logic [N_RULES-1:0] io_inB,
    output logic               io_outResultValid,
    output logic               io_outResult,
    output logic               io_done,
    output logic [IDX_W-1:0]   io_outIndex
);

    // Counter must be able to express WIDTH itself so it never has to wrap.
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    // Per-rule comparison state of the serial min: once A and B differ, the smaller
    // operand is known for all remaining bits.
    localparam logic [1:0] TIE    = 2'b00;
    localparam logic [1:0] A_LESS = 2'b01;
    localparam logic [1:0] B_LESS = 2'b10;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);

    logic [0:0]               fsm_q, fsm_d;
    logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
    logic [N_RULES-1:0][1:0]  rule_state_q, rule_state_d;
    logic [N_RULES-1:0]       cand_q, cand_d;

    logic                     valid_q, valid_d;
    logic                     result_q, result_d;
    logic                     done_q, done_d;
    logic [IDX_W-1:0]         index_q, index_d;

    logic [N_RULES-1:0]       min_bit;
    logic                     max_bit;
    logic                     consume;
    logic                     last_bit;
    logic [N_RULES-1:0]       cand_upd;
    logic [IDX_W-1:0]         low_idx;

    assign consume  = (fsm_q == RUN) && io_inValid;
    assign last_bit = (bit_cnt_q == LAST_BIT);

    // Serial min per rule: follow the operand already known to be smaller, AND while tied.
    always_comb begin
        min_bit = '0;
        for (int i = 0; i < N_RULES; i++) begin
            unique case (rule_state_q[i])
                A_LESS:  min_bit[i] = io_inA[i];
                B_LESS:  min_bit[i] = io_inB[i];
                default: min_bit[i] = io_inA[i] & io_inB[i];
            endcase
        end
    end

    // Serial max over the surviving candidates; a 1 bit eliminates rules that output 0.
    always_comb begin
        max_bit  = |(min_bit & cand_q);
        cand_upd = max_bit ? (cand_q & min_bit) : cand_q;
    end

    // Lowest set index of the updated candidate mask; the mask is never empty.
    always_comb begin
        low_idx = '0;
        for (int i = N_RULES - 1; i >= 0; i--) begin
            if (cand_upd[i]) begin
                low_idx = IDX_W'(unsigned'(i));
            end
        end
    end

    // Next-state logic for the FSM, bit counter, min states and candidate mask.
    always_comb begin
        fsm_d        = fsm_q;
        bit_cnt_d    = bit_cnt_q;
        rule_state_d = rule_state_q;
        cand_d       = cand_q;

        unique case (fsm_q)
            IDLE: begin
                if (io_start) begin
                    fsm_d        = RUN;
                    bit_cnt_d    = '0;
                    rule_state_d = '0;
                    cand_d       = '1;
                end
            end
            default: begin
                // io_start is deliberately ignored here; a run cannot be restarted.
                if (io_inValid) begin
                    for (int i = 0; i < N_RULES; i++) begin
                        if (rule_state_q[i] == TIE) begin
                            if (!io_inA[i] && io_inB[i]) begin
                                rule_state_d[i] = A_LESS;
                            end else if (io_inA[i] && !io_inB[i]) begin
                                rule_state_d[i] = B_LESS;
                            end
                        end
                    end
                    cand_d = cand_upd;
                    if (bit_cnt_q != FULL_CNT) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                    if (last_bit) begin
                        fsm_d = IDLE;
                    end
                end
            end
        endcase
    end

    // Registered output stage: one cycle of latency per consumed bit.
    always_comb begin
        valid_d  = consume;
        result_d = consume & max_bit;
        done_d   = consume & last_bit;
        index_d  = (consume && last_bit) ? low_idx : index_q;
    end

    // Inference state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_q        <= IDLE;
            bit_cnt_q    <= '0;
            rule_state_q <= '0;
            cand_q       <= '1;
        end else begin
            fsm_q        <= fsm_d;
            bit_cnt_q    <= bit_cnt_d;
            rule_state_q <= rule_state_d;
            cand_q       <= cand_d;
        end
    end

    // Output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q  <= 1'b0;
            result_q <= 1'b0;
            done_q   <= 1'b0;
            index_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            done_q   <= done_d;
            index_q  <= index_d;
        end
    end

    assign io_outResultValid = valid_q;
    assign io_outResult      = result_q;
    assign io_done           = done_q;
    assign io_outIndex       = index_q;

endmodule

// File: tb/tb_regular_min_max_inference.sv
// Scoreboard bench for regular_min_max_inference: the driver pushes the expected output
// of every driven RUN cycle tagged with the cycle it must appear in; the monitor pops
// and compares on each falling edge, and otherwise requires the outputs to be quiet.
module tb_regular_min_max_inference;

    localparam int N  = 4;
    localparam int W  = 10;
    localparam int IW = 2;

    typedef logic [W-1:0] vec_t [N];
    typedef struct {
        int            cyc;
        logic          valid;
        logic          res;
        logic          done;
        logic [IW-1:0] idx;
    } exp_t;

    exp_t sb[$];

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          io_start = 1'b0;
    logic          io_inValid = 1'b0;
    logic [N-1:0]  io_inA = '0;
    logic [N-1:0]  io_inB = '0;
    logic          io_outResultValid;
    logic          io_outResult;
    logic          io_done;
    logic [IW-1:0] io_outIndex;

    int            cyc = 0;
    int            nvec = 0;
    int            nerr = 0;
    logic [IW-1:0] hold_idx = '0;

    regular_min_max_inference #(
        .N_RULES (N),
        .WIDTH   (W),
        .IDX_W   (IW)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .io_start          (io_start),
        .io_inValid        (io_inValid),
        .io_inA            (io_inA),
        .io_inB            (io_inB),
        .io_outResultValid (io_outResultValid),
        .io_outResult      (io_outResult),
        .io_done           (io_done),
        .io_outIndex       (io_outIndex)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic void check(input string name, input int act, input int req);
        nvec++;
        if (act != req) begin
            nerr++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endfunction

    // Reference: strongest rule is max over min(A,B); ties go to the lowest index.
    function automatic void model(input vec_t a, input vec_t b,
                                  output logic [W-1:0] mx, output logic [IW-1:0] idx);
        int best = -1;
        int mn;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            mn = (a[i] < b[i]) ? int'(a[i]) : int'(b[i]);
            if (mn > best) begin
                best = mn;
                idx  = IW'(i);
            end
        end
        mx = W'(best);
    endfunction

    task automatic drive(input logic st, input logic v, input logic [N-1:0] a,
                         input logic [N-1:0] b);
        @(posedge clock);
        #1;
        io_start   = st;
        io_inValid = v;
        io_inA     = a;
        io_inB     = b;
    endtask

    task automatic push(input logic v, input logic r, input logic d, input logic [IW-1:0] ix);
        exp_t e;
        e.cyc = cyc + 1; e.valid = v; e.res = r; e.done = d; e.idx = ix;
        sb.push_back(e);
    endtask

    // Idle cycles with random, possibly "valid" inputs that the DUT must ignore.
    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            drive(1'b0, 1'($urandom), N'($urandom), N'($urandom));
        end
    endtask

    task automatic stall(input int n);
        for (int c = 0; c < n; c++) begin
            drive(1'b0, 1'b0, N'($urandom), N'($urandom));
            push(1'b0, 1'b0, 1'b0, '0);
        end
    endtask

    // One inference. s1/s2: bit after which to stall 2 cycles; r1/r2: bits that also
    // carry io_start; ab: number of bits after which reset is asserted (-1 = none).
    task automatic run_case(input vec_t a, input vec_t b, input int s1, input int s2,
                            input int r1, input int r2, input int ab, input bit rnd);
        logic [W-1:0]  mx;
        logic [IW-1:0] ix;
        logic [N-1:0]  av, bv;
        model(a, b, mx, ix);
        drive(1'b1, 1'b0, N'($urandom), N'($urandom));
        push(1'b0, 1'b0, 1'b0, '0);
        for (int k = 0; k < W; k++) begin
            if (k == ab) begin
                @(posedge clock);
                #1;
                reset = 1'b1; io_start = 1'b0; io_inValid = 1'b0;
                #1;
                check("rst_valid", int'(io_outResultValid), 0);
                check("rst_result", int'(io_outResult), 0);
                check("rst_done", int'(io_done), 0);
                check("rst_index", int'(io_outIndex), 0);
                @(posedge clock);
                #1;
                reset = 1'b0;
                return;
            end
            for (int i = 0; i < N; i++) begin
                av[i] = a[i][W-1-k];
                bv[i] = b[i][W-1-k];
            end
            drive(k == r1 || k == r2, 1'b1, av, bv);
            // The bit driven just before a reset is never observed.
            if (!(ab >= 0 && k == ab - 1)) begin
                push(1'b1, mx[W-1-k], k == W - 1, ix);
            end
            if (k != W - 1) begin
                if (k == s1 || k == s2) stall(2);
                if (rnd && $urandom_range(3) == 0) stall(1);
            end
        end
    endtask

    // Monitor: compare scheduled expectations, require quiet outputs otherwise.
    always @(negedge clock) begin
        exp_t e;
        if (reset) hold_idx = '0;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            check("out_valid", int'(io_outResultValid), int'(e.valid));
            check("out_result", int'(io_outResult), int'(e.res));
            check("out_done", int'(io_done), int'(e.done));
            if (e.done) begin
                check("out_index", int'(io_outIndex), int'(e.idx));
                hold_idx = e.idx;
            end else begin
                check("held_index", int'(io_outIndex), int'(hold_idx));
            end
        end else begin
            check("idle_valid", int'(io_outResultValid), 0);
            check("idle_done", int'(io_done), 0);
            check("idle_index", int'(io_outIndex), int'(hold_idx));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t basic_a, basic_b, tie_a, tie_b, zero_v, ra, rb;
        int   j;
        basic_a = '{10'd600, 10'd512, 10'd100, 10'd1023};
        basic_b = '{10'd300, 10'd512, 10'd900, 10'd0};
        tie_a   = '{10'd700, 10'd300, 10'd900, 10'd0};
        tie_b   = '{10'd800, 10'd300, 10'd700, 10'd0};
        zero_v  = '{10'd0, 10'd0, 10'd0, 10'd0};

        #1;
        check("reset_valid", int'(io_outResultValid), 0);
        check("reset_result", int'(io_outResult), 0);
        check("reset_done", int'(io_done), 0);
        check("reset_index", int'(io_outIndex), 0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        idle(3);

        run_case(basic_a, basic_b, -1, -1, -1, -1, -1, 1'b0);
        idle(3);
        run_case(tie_a, tie_b, -1, -1, -1, -1, -1, 1'b0);
        idle(3);
        run_case(zero_v, zero_v, -1, -1, -1, -1, -1, 1'b0);
        idle(3);
        run_case(basic_a, basic_b, 2, 6, -1, -1, -1, 1'b0);
        idle(3);
        // Extra starts mid-run and alongside the final bit must both be ignored.
        run_case(basic_a, basic_b, -1, -1, 5, W - 1, -1, 1'b0);
        idle(4);
        run_case(basic_a, basic_b, -1, -1, -1, -1, 4, 1'b0);
        idle(3);
        run_case(tie_a, tie_b, -1, -1, -1, -1, -1, 1'b0);
        idle(2);

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                ra[i] = W'($urandom_range(0, (1 << W) - 1));
                rb[i] = W'($urandom_range(0, (1 << W) - 1));
            end
            if ($urandom_range(2) == 0) begin
                j = $urandom_range(1, N - 1);
                ra[j] = ra[0];
                rb[j] = rb[0];
            end
            run_case(ra, rb, -1, -1, -1, ($urandom_range(3) == 0) ? W - 1 : -1, -1, 1'b1);
            idle($urandom_range(0, 3));
        end

        idle(2);
        for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clock);
        if (sb.size() > 0) begin
            nerr++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
